mem_access_sequencer: RTL and testbench

Parametrised memory-transfer sequencer for the ARM-style datapath. It takes one decoded load/store request (direction, U/P/W/B bits, base, offset, word count) and drives the RAM handshake (MFA/Moc) one word at a time. It produces load data and the base-register writeback, and aborts on a Moc timeout. It replaces the per-addressing-mode load/store state chains in the control unit with one reusable block that also supports multi-word (block) transfers.

---
 rtl/mem_access_sequencer_if.sv | 47 ++++
 rtl/mem_access_sequencer.sv | 130 +++++++++++++
 tb/tb_mem_access_sequencer.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_sequencer_if.sv
// Request and RAM-handshake bundle for mem_access_sequencer.
interface mem_access_sequencer_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 4
);
  // decoded request
  logic          Start;
  logic          L;
  logic          U;
  logic          P;
  logic          W;
  logic          B;
  logic [AW-1:0] Base;
  logic [AW-1:0] Offset;
  logic [CW-1:0] Count;
  logic [DW-1:0] StoreData;
  // RAM side
  logic [DW-1:0] MemDataIn;
  logic          Moc;
  logic          MFA;
  logic          MemRW;
  logic          MemSize;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemDataOut;
  // results
  logic [DW-1:0] LoadData;
  logic          LoadValid;
  logic [CW-1:0] WordIdx;
  logic          WbEn;
  logic [AW-1:0] WbAddr;
  logic          Busy;
  logic          Done;
  logic          Timeout;

  modport master (
    input  Start, L, U, P, W, B, Base, Offset, Count, StoreData, MemDataIn, Moc,
    output MFA, MemRW, MemSize, MemAddr, MemDataOut, LoadData, LoadValid,
           WordIdx, WbEn, WbAddr, Busy, Done, Timeout
  );

  modport slave (
    output Start, L, U, P, W, B, Base, Offset, Count, StoreData, MemDataIn, Moc,
    input  MFA, MemRW, MemSize, MemAddr, MemDataOut, LoadData, LoadValid,
           WordIdx, WbEn, WbAddr, Busy, Done, Timeout
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// Single/block load-store sequencer driving an MFA/Moc RAM handshake.
module mem_access_sequencer #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned CW      = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                  Clk,
  input  logic                  Reset,
  mem_access_sequencer_if.master bus
);

  localparam int unsigned TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned TLAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_RELEASE, S_FINISH, S_ABORT
  } state_t;

  state_t        state;
  logic          req_l;
  logic          req_u;
  logic          req_wb;
  logic [CW-1:0] last_idx;
  logic [AW-1:0] wb_val;
  logic [TW-1:0] wcnt;

  logic [AW-1:0] oa_c;
  logic [CW-1:0] n_c;
  logic [AW-1:0] step_c;
  logic [AW-1:0] wb_c;

  // Request decode: offset address, word count, and final base writeback value.
  always_comb begin
    oa_c   = bus.U ? bus.Base + bus.Offset : bus.Base - bus.Offset;
    n_c    = (bus.B || bus.Count == '0) ? CW'(1) : bus.Count;
    step_c = AW'(n_c) << 2;
    wb_c   = (n_c == CW'(1)) ? oa_c
           : (bus.U ? bus.Base + step_c : bus.Base - step_c);
  end

  // Transfer FSM; every bus output is a register updated here.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state          <= S_IDLE;
      req_l          <= 1'b0;
      req_u          <= 1'b0;
      req_wb         <= 1'b0;
      last_idx       <= '0;
      wb_val         <= '0;
      wcnt           <= '0;
      bus.MFA        <= 1'b0;
      bus.MemRW      <= 1'b0;
      bus.MemSize    <= 1'b0;
      bus.MemAddr    <= '0;
      bus.MemDataOut <= '0;
      bus.LoadData   <= '0;
      bus.LoadValid  <= 1'b0;
      bus.WordIdx    <= '0;
      bus.WbEn       <= 1'b0;
      bus.WbAddr     <= '0;
      bus.Busy       <= 1'b0;
      bus.Done       <= 1'b0;
      bus.Timeout    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.Start) begin
            req_l          <= bus.L;
            req_u          <= bus.U;
            req_wb         <= !bus.P || bus.W;
            last_idx       <= n_c - CW'(1);
            wb_val         <= wb_c;
            wcnt           <= '0;
            bus.MemAddr    <= bus.P ? oa_c : bus.Base;
            bus.MemDataOut <= DW'(bus.StoreData);
            bus.WordIdx    <= '0;
            bus.MFA        <= 1'b1;
            bus.MemRW      <= bus.L;
            bus.MemSize    <= bus.B;
            bus.Busy       <= 1'b1;
            state          <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Moc is checked before the timeout so a same-cycle completion wins.
          if (bus.Moc) begin
            if (req_l) bus.LoadData <= DW'(bus.MemDataIn);
            bus.LoadValid <= req_l;
            bus.MFA       <= 1'b0;
            state         <= S_RELEASE;
          end else if (TIMEOUT != 0 && wcnt == TW'(TLAST)) begin
            bus.MFA     <= 1'b0;
            bus.Done    <= 1'b1;
            bus.Timeout <= 1'b1;
            state       <= S_ABORT;
          end else begin
            wcnt <= wcnt + TW'(1);
          end
        end
        S_RELEASE: begin
          // One MFA-low cycle so a level Moc is never counted twice.
          bus.LoadValid <= 1'b0;
          if (bus.WordIdx == last_idx) begin
            bus.Done   <= 1'b1;
            bus.WbEn   <= req_wb;
            bus.WbAddr <= wb_val;
            state      <= S_FINISH;
          end else begin
            bus.WordIdx    <= bus.WordIdx + CW'(1);
            bus.MemAddr    <= req_u ? bus.MemAddr + AW'(4) : bus.MemAddr - AW'(4);
            bus.MemDataOut <= DW'(bus.StoreData);
            bus.MFA        <= 1'b1;
            wcnt           <= '0;
            state          <= S_ISSUE;
          end
        end
        S_FINISH, S_ABORT: begin
          bus.Done    <= 1'b0;
          bus.WbEn    <= 1'b0;
          bus.Timeout <= 1'b0;
          bus.Busy    <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed self-checking bench for mem_access_sequencer.
module tb_mem_access_sequencer;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 Clk = ~Clk;

  mem_access_sequencer_if #(.AW(32), .DW(32), .CW(4)) b ();

  mem_access_sequencer #(.AW(32), .DW(32), .CW(4), .TIMEOUT(15)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (b)
  );

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_req(input logic l, input logic u, input logic p, input logic w,
                         input logic bb, input logic [31:0] base, input logic [31:0] off,
                         input logic [3:0] cnt);
    b.L = l; b.U = u; b.P = p; b.W = w; b.B = bb;
    b.Base = base; b.Offset = off; b.Count = cnt;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    b.Start = 0; b.Moc = 0; b.MemDataIn = '0; b.StoreData = '0;
    set_req(0, 0, 0, 0, 0, 32'h0, 32'h0, 4'd0);
    tick(); tick();
    n_cmp++;
    if ({b.MFA, b.MemRW, b.MemSize, b.LoadValid, b.WbEn, b.Busy, b.Done, b.Timeout} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 00000000",
               {b.MFA, b.MemRW, b.MemSize, b.LoadValid, b.WbEn, b.Busy, b.Done, b.Timeout});
    end
    n_cmp++;
    if (b.MemAddr !== 32'h0 || b.MemDataOut !== 32'h0 || b.LoadData !== 32'h0 ||
        b.WbAddr !== 32'h0 || b.WordIdx !== 4'h0) begin
      n_err++;
      $display("FAIL reset_buses: addr=%h dout=%h ld=%h wb=%h idx=%h want all 0",
               b.MemAddr, b.MemDataOut, b.LoadData, b.WbAddr, b.WordIdx);
    end
    Reset = 1'b1;
    tick();
  endtask

  task automatic test_load_pre();
    set_req(1, 1, 1, 0, 0, 32'h100, 32'h8, 4'd1);
    b.Moc = 1; b.MemDataIn = 32'hCAFE_F00D; b.Start = 1;
    tick(); b.Start = 0;
    n_cmp++;
    if (b.MFA !== 1'b1 || b.MemAddr !== 32'h108 || b.MemRW !== 1'b1 || b.Busy !== 1'b1) begin
      n_err++;
      $display("FAIL load_issue: mfa=%b addr=%h rw=%b busy=%b want 1 108 1 1",
               b.MFA, b.MemAddr, b.MemRW, b.Busy);
    end
    tick();
    n_cmp++;
    if (b.MFA !== 1'b0 || b.LoadValid !== 1'b1 || b.LoadData !== 32'hCAFE_F00D) begin
      n_err++;
      $display("FAIL load_release: mfa=%b lv=%b ld=%h want 0 1 cafef00d",
               b.MFA, b.LoadValid, b.LoadData);
    end
    tick();
    n_cmp++;
    if (b.Done !== 1'b1 || b.WbEn !== 1'b0 || b.LoadValid !== 1'b0 || b.Timeout !== 1'b0) begin
      n_err++;
      $display("FAIL load_finish: done=%b wben=%b lv=%b to=%b want 1 0 0 0",
               b.Done, b.WbEn, b.LoadValid, b.Timeout);
    end
    tick();
    n_cmp++;
    if (b.Busy !== 1'b0 || b.Done !== 1'b0 || b.LoadData !== 32'hCAFE_F00D) begin
      n_err++;
      $display("FAIL load_idle: busy=%b done=%b ld=%h want 0 0 cafef00d",
               b.Busy, b.Done, b.LoadData);
    end
  endtask

  task automatic test_store_post();
    int mfa_n;
    mfa_n = 0;
    set_req(0, 0, 0, 0, 0, 32'h200, 32'h10, 4'd1);
    b.Moc = 0; b.StoreData = 32'h1234_5678; b.Start = 1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      b.Start = 0;
      if (b.MFA) mfa_n++;
      if (c == 1) begin
        n_cmp++;
        if (b.MemAddr !== 32'h200 || b.MemRW !== 1'b0 || b.MemDataOut !== 32'h1234_5678) begin
          n_err++;
          $display("FAIL store_issue: addr=%h rw=%b dout=%h want 200 0 12345678",
                   b.MemAddr, b.MemRW, b.MemDataOut);
        end
      end
      if (c == 4) b.Moc = 1;
      if (c == 5) begin
        b.Moc = 0;
        n_cmp++;
        if (b.LoadValid !== 1'b0 || b.MFA !== 1'b0) begin
          n_err++;
          $display("FAIL store_release: lv=%b mfa=%b want 0 0", b.LoadValid, b.MFA);
        end
      end
      if (c == 6) begin
        n_cmp++;
        if (b.Done !== 1'b1 || b.WbEn !== 1'b1 || b.WbAddr !== 32'h1F0) begin
          n_err++;
          $display("FAIL store_wb: done=%b wben=%b wbaddr=%h want 1 1 1f0",
                   b.Done, b.WbEn, b.WbAddr);
        end
      end
    end
    n_cmp++;
    if (mfa_n !== 4) begin
      n_err++;
      $display("FAIL store_mfa_cycles: got %0d want 4", mfa_n);
    end
  endtask

  task automatic test_block_load();
    int lv_n;
    logic [31:0] exp_a;
    lv_n = 0;
    set_req(1, 1, 0, 1, 0, 32'h40, 32'h8, 4'd3);
    b.Moc = 1; b.Start = 1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      b.MemDataIn = 32'hA000_0000 + 32'(c);
      if (c == 1) b.Base = 32'h999;
      if (c == 6) b.Start = 0;
      if (b.LoadValid) lv_n++;
      if (c == 1 || c == 3 || c == 5) begin
        exp_a = 32'h40 + 32'((c - 1) * 2);
        n_cmp++;
        if (b.MFA !== 1'b1 || b.MemAddr !== exp_a || b.WordIdx !== 4'((c - 1) / 2)) begin
          n_err++;
          $display("FAIL block_issue%0d: mfa=%b addr=%h idx=%0d want 1 %h %0d",
                   c, b.MFA, b.MemAddr, b.WordIdx, exp_a, (c - 1) / 2);
        end
      end
      if (c == 2 || c == 4 || c == 6) begin
        n_cmp++;
        if (b.MFA !== 1'b0 || b.LoadValid !== 1'b1) begin
          n_err++;
          $display("FAIL block_release%0d: mfa=%b lv=%b want 0 1", c, b.MFA, b.LoadValid);
        end
      end
      if (c == 6) begin
        n_cmp++;
        if (b.LoadData !== 32'hA000_0005) begin
          n_err++;
          $display("FAIL block_lastdata: got %h want a0000005", b.LoadData);
        end
      end
      if (c == 7) begin
        n_cmp++;
        if (b.Done !== 1'b1 || b.WbEn !== 1'b1 || b.WbAddr !== 32'h4C) begin
          n_err++;
          $display("FAIL block_wb: done=%b wben=%b wbaddr=%h want 1 1 4c",
                   b.Done, b.WbEn, b.WbAddr);
        end
      end
      if (c == 8) begin
        n_cmp++;
        if (b.Busy !== 1'b0) begin
          n_err++;
          $display("FAIL block_idle: busy=%b want 0", b.Busy);
        end
      end
    end
    n_cmp++;
    if (lv_n !== 3) begin
      n_err++;
      $display("FAIL block_lv_count: got %0d want 3", lv_n);
    end
  endtask

  task automatic test_byte_store();
    int rises;
    logic prev;
    rises = 0; prev = 1'b0;
    set_req(0, 1, 1, 1, 1, 32'h300, 32'h3, 4'd5);
    b.Moc = 1; b.Start = 1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      b.Start = 0;
      if (b.MFA && !prev) rises++;
      prev = b.MFA;
      if (c == 1) begin
        n_cmp++;
        if (b.MemSize !== 1'b1 || b.MemAddr !== 32'h303) begin
          n_err++;
          $display("FAIL byte_issue: size=%b addr=%h want 1 303", b.MemSize, b.MemAddr);
        end
      end
      if (c == 3) begin
        n_cmp++;
        if (b.Done !== 1'b1 || b.WbEn !== 1'b1 || b.WbAddr !== 32'h303) begin
          n_err++;
          $display("FAIL byte_wb: done=%b wben=%b wbaddr=%h want 1 1 303",
                   b.Done, b.WbEn, b.WbAddr);
        end
      end
    end
    n_cmp++;
    if (rises !== 1) begin
      n_err++;
      $display("FAIL byte_transfers: got %0d want 1", rises);
    end
  endtask

  task automatic test_timeout();
    int mfa_n;
    logic early;
    mfa_n = 0; early = 1'b0;
    set_req(1, 1, 1, 0, 0, 32'h500, 32'h0, 4'd1);
    b.Moc = 0; b.Start = 1;
    for (int c = 1; c <= 17; c++) begin
      tick();
      b.Start = 0;
      if (b.MFA) mfa_n++;
      if (c < 16 && b.Done) early = 1'b1;
      if (c == 16) begin
        n_cmp++;
        if (b.Done !== 1'b1 || b.Timeout !== 1'b1 || b.WbEn !== 1'b0 ||
            b.LoadValid !== 1'b0 || b.MFA !== 1'b0) begin
          n_err++;
          $display("FAIL timeout_abort: done=%b to=%b wben=%b lv=%b mfa=%b want 1 1 0 0 0",
                   b.Done, b.Timeout, b.WbEn, b.LoadValid, b.MFA);
        end
      end
      if (c == 17) begin
        n_cmp++;
        if (b.Busy !== 1'b0 || b.Timeout !== 1'b0) begin
          n_err++;
          $display("FAIL timeout_idle: busy=%b to=%b want 0 0", b.Busy, b.Timeout);
        end
      end
    end
    n_cmp++;
    if (mfa_n !== 15 || early !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_mfa_cycles: got %0d early_done=%b want 15 0", mfa_n, early);
    end
  endtask

  task automatic test_moc_wins();
    set_req(1, 1, 1, 1, 0, 32'h700, 32'h4, 4'd1);
    b.Moc = 0; b.MemDataIn = 32'h5555_AAAA; b.Start = 1;
    for (int c = 1; c <= 18; c++) begin
      tick();
      b.Start = 0;
      if (c == 15) b.Moc = 1;
      if (c == 16) begin
        b.Moc = 0;
        n_cmp++;
        if (b.LoadValid !== 1'b1 || b.Timeout !== 1'b0 || b.Done !== 1'b0) begin
          n_err++;
          $display("FAIL mocwins_release: lv=%b to=%b done=%b want 1 0 0",
                   b.LoadValid, b.Timeout, b.Done);
        end
      end
      if (c == 17) begin
        n_cmp++;
        if (b.Done !== 1'b1 || b.Timeout !== 1'b0 || b.WbEn !== 1'b1 || b.WbAddr !== 32'h704) begin
          n_err++;
          $display("FAIL mocwins_finish: done=%b to=%b wben=%b wbaddr=%h want 1 0 1 704",
                   b.Done, b.Timeout, b.WbEn, b.WbAddr);
        end
      end
    end
  endtask

  task automatic test_wait_clear();
    int w, lv_n;
    logic done_seen, to_seen, wb_seen;
    w = 0; lv_n = 0; done_seen = 1'b0; to_seen = 1'b0; wb_seen = 1'b0;
    set_req(1, 1, 1, 0, 0, 32'h600, 32'h20, 4'd2);
    b.Moc = 0; b.Start = 1;
    for (int c = 1; c <= 60 && !done_seen; c++) begin
      tick();
      b.Start = 0;
      if (b.Done) begin
        done_seen = 1'b1; to_seen = b.Timeout; wb_seen = b.WbEn;
      end
      if (b.LoadValid) lv_n++;
      if (b.MFA) begin
        w++;
        b.Moc = (w >= 12);
      end else begin
        w = 0;
        b.Moc = 0;
      end
    end
    b.Moc = 0;
    n_cmp++;
    if (done_seen !== 1'b1 || to_seen !== 1'b0 || wb_seen !== 1'b0 || lv_n !== 2) begin
      n_err++;
      $display("FAIL wait_clear: done=%b to=%b wben=%b lv=%0d want 1 0 0 2",
               done_seen, to_seen, wb_seen, lv_n);
    end
    tick();
  endtask

  task automatic test_wrap_desc();
    set_req(1, 0, 0, 1, 0, 32'h4, 32'h0, 4'd3);
    b.Moc = 1; b.Start = 1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      b.Start = 0;
      if (c == 3) begin
        n_cmp++;
        if (b.MemAddr !== 32'h0) begin
          n_err++;
          $display("FAIL wrap_addr1: got %h want 00000000", b.MemAddr);
        end
      end
      if (c == 5) begin
        n_cmp++;
        if (b.MemAddr !== 32'hFFFF_FFFC) begin
          n_err++;
          $display("FAIL wrap_addr2: got %h want fffffffc", b.MemAddr);
        end
      end
      if (c == 7) begin
        n_cmp++;
        if (b.WbEn !== 1'b1 || b.WbAddr !== 32'hFFFF_FFF8) begin
          n_err++;
          $display("FAIL wrap_wb: wben=%b wbaddr=%h want 1 fffffff8", b.WbEn, b.WbAddr);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    set_req(1, 1, 0, 0, 0, 32'h80, 32'h0, 4'd3);
    b.Moc = 1; b.MemDataIn = 32'h1111_2222; b.Start = 1;
    tick(); b.Start = 0;
    tick(); tick();
    n_cmp++;
    if (b.WordIdx !== 4'd1 || b.MFA !== 1'b1 || b.MemAddr !== 32'h84) begin
      n_err++;
      $display("FAIL mid_precond: idx=%0d mfa=%b addr=%h want 1 1 84", b.WordIdx, b.MFA, b.MemAddr);
    end
    Reset = 1'b0;
    tick();
    n_cmp++;
    if ({b.MFA, b.MemRW, b.MemSize, b.LoadValid, b.WbEn, b.Busy, b.Done, b.Timeout} !== 8'h00 ||
        b.MemAddr !== 32'h0 || b.WordIdx !== 4'h0 || b.LoadData !== 32'h0 || b.WbAddr !== 32'h0) begin
      n_err++;
      $display("FAIL mid_reset: flags=%b addr=%h idx=%0d ld=%h wb=%h want all 0",
               {b.MFA, b.MemRW, b.MemSize, b.LoadValid, b.WbEn, b.Busy, b.Done, b.Timeout},
               b.MemAddr, b.WordIdx, b.LoadData, b.WbAddr);
    end
    Reset = 1'b1;
    tick();
    set_req(1, 1, 0, 0, 0, 32'h90, 32'h0, 4'd1);
    b.Start = 1;
    tick(); b.Start = 0;
    n_cmp++;
    if (b.MFA !== 1'b1 || b.WordIdx !== 4'd0 || b.MemAddr !== 32'h90) begin
      n_err++;
      $display("FAIL mid_restart: mfa=%b idx=%0d addr=%h want 1 0 90", b.MFA, b.WordIdx, b.MemAddr);
    end
    tick(); tick();
    n_cmp++;
    if (b.Done !== 1'b1 || b.WbEn !== 1'b1 || b.WbAddr !== 32'h90) begin
      n_err++;
      $display("FAIL mid_restart_wb: done=%b wben=%b wbaddr=%h want 1 1 90", b.Done, b.WbEn, b.WbAddr);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_load_pre();
    test_store_post();
    test_block_load();
    test_byte_store();
    test_timeout();
    test_moc_wins();
    test_wait_clear();
    test_wrap_desc();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
